// File: rtl/trap_controller_pkg.sv
// Shared types and constants for the machine-mode trap controller.
package trap_controller_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ENTER,
        RET,
        REDIRECT
    } trap_state_e;

    // Interrupt cause codes
    localparam logic [30:0] CAUSE_MEI      = 31'd11;
    localparam logic [30:0] CAUSE_MSI      = 31'd3;
    localparam logic [30:0] CAUSE_MTI      = 31'd7;
    // Synchronous exception cause codes
    localparam logic [30:0] CAUSE_MISALIGN = 31'd0;
    localparam logic [30:0] CAUSE_ILLEGAL  = 31'd2;
    localparam logic [30:0] CAUSE_BREAK    = 31'd3;
    localparam logic [30:0] CAUSE_ECALL    = 31'd11;

    typedef struct packed {
        logic [23:0] rsvd_hi;
        logic        mpie;     // [7]
        logic [2:0]  rsvd_mid;
        logic        mie;      // [3]
        logic [2:0]  rsvd_lo;
    } mstatus_t;

    typedef struct packed {
        logic [19:0] rsvd_hi;
        logic        meie;     // [11]
        logic [2:0]  rsvd_b;
        logic        mtie;     // [7]
        logic [2:0]  rsvd_a;
        logic        msie;     // [3]
        logic [2:0]  rsvd_lo;
    } mie_t;

    typedef struct packed {
        logic [19:0] rsvd_hi;
        logic        meip;     // [11]
        logic [2:0]  rsvd_b;
        logic        mtip;     // [7]
        logic [2:0]  rsvd_a;
        logic        msip;     // [3]
        logic [2:0]  rsvd_lo;
    } mip_t;

endpackage

// File: rtl/trap_controller_cause_arbiter.sv
// Combinational trap-cause priority arbiter: interrupts (MEI, MSI, MTI),
// then synchronous exceptions (misaligned, illegal, ebreak, ecall), then mret.
module trap_cause_arbiter
    import trap_controller_pkg::*;
(
    input  logic        irq_mei,
    input  logic        irq_msi,
    input  logic        irq_mti,
    input  logic        misaligned,
    input  logic        illegal,
    input  logic        ebreak,
    input  logic        ecall,
    input  logic        mret,
    output logic        take_trap,
    output logic        take_mret,
    output logic        is_irq,
    output logic [30:0] cause
);

    // Fixed-priority selection; an mret only wins when nothing else is pending
    always_comb begin
        take_trap = 1'b1;
        take_mret = 1'b0;
        is_irq    = 1'b0;
        cause     = '0;
        if (irq_mei) begin
            is_irq = 1'b1;
            cause  = CAUSE_MEI;
        end else if (irq_msi) begin
            is_irq = 1'b1;
            cause  = CAUSE_MSI;
        end else if (irq_mti) begin
            is_irq = 1'b1;
            cause  = CAUSE_MTI;
        end else if (misaligned) begin
            cause = CAUSE_MISALIGN;
        end else if (illegal) begin
            cause = CAUSE_ILLEGAL;
        end else if (ebreak) begin
            cause = CAUSE_BREAK;
        end else if (ecall) begin
            cause = CAUSE_ECALL;
        end else begin
            take_trap = 1'b0;
            take_mret = mret;
        end
    end

endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap controller: selects traps/mret at commit, strobes the CSR
// block, then flushes and redirects fetch.
// Optional macro TRAP_VECTORED_EN: vectored interrupt dispatch when mtvec mode is 1.
module trap_controller
    import trap_controller_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_sync,
    input  logic        stall_n,
    input  logic        instr_valid,
    input  logic [31:0] instr_pc,
    input  logic        ecall,
    input  logic        ebreak,
    input  logic        illegal_instr,
    input  logic        instr_misaligned,
    input  logic        mret,
    input  mstatus_t    csr_mstatus,
    input  mie_t        csr_mie,
    input  mip_t        csr_mip,
    input  logic [31:0] csr_mtvec,
    input  logic [31:0] csr_mepc,
    output logic        exception_occurred,
    output logic        exception_returned,
    output logic [31:0] new_mepc,
    output logic [31:0] new_mcause,
    output logic [31:0] new_mtval,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    trap_state_e state;
    logic        detect;
    logic        irq_mei, irq_msi, irq_mti;
    logic        take_trap, take_mret, is_irq;
    logic [30:0] cause;
    logic [31:0] trap_target;
    logic        unused_csr_bits;

    assign unused_csr_bits = ^{csr_mstatus, csr_mie, csr_mip, csr_mtvec[1:0]};

    assign detect  = instr_valid && stall_n;
    assign irq_mei = csr_mstatus.mie && csr_mie.meie && csr_mip.meip;
    assign irq_msi = csr_mstatus.mie && csr_mie.msie && csr_mip.msip;
    assign irq_mti = csr_mstatus.mie && csr_mie.mtie && csr_mip.mtip;

    assign new_mtval = '0;

    trap_cause_arbiter u_arbiter (
        .irq_mei    (irq_mei),
        .irq_msi    (irq_msi),
        .irq_mti    (irq_mti),
        .misaligned (instr_misaligned),
        .illegal    (illegal_instr),
        .ebreak     (ebreak),
        .ecall      (ecall),
        .mret       (mret),
        .take_trap  (take_trap),
        .take_mret  (take_mret),
        .is_irq     (is_irq),
        .cause      (cause)
    );

    // Trap target from mtvec; cause is taken from the mcause latched on entry
    always_comb begin
        trap_target = {csr_mtvec[31:2], 2'b00};
`ifdef TRAP_VECTORED_EN
        if (csr_mtvec[1:0] == 2'b01 && new_mcause[31])
            trap_target = {csr_mtvec[31:2], 2'b00} + {new_mcause[29:0], 2'b00};
`endif
    end

    // Trap sequencer with registered strobes: IDLE -> ENTER/RET -> REDIRECT -> IDLE
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            state              <= IDLE;
            exception_occurred <= 1'b0;
            exception_returned <= 1'b0;
            flush              <= 1'b0;
            redirect_valid     <= 1'b0;
            new_mepc           <= '0;
            new_mcause         <= '0;
            redirect_pc        <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (detect && take_trap) begin
                        state              <= ENTER;
                        exception_occurred <= 1'b1;
                        flush              <= 1'b1;
                        new_mepc           <= instr_pc;
                        new_mcause         <= {is_irq, cause};
                    end else if (detect && take_mret) begin
                        state              <= RET;
                        exception_returned <= 1'b1;
                        flush              <= 1'b1;
                    end
                end
                ENTER: begin
                    state              <= REDIRECT;
                    exception_occurred <= 1'b0;
                    flush              <= 1'b0;
                    redirect_valid     <= 1'b1;
                    redirect_pc        <= trap_target;
                end
                RET: begin
                    state              <= REDIRECT;
                    exception_returned <= 1'b0;
                    flush              <= 1'b0;
                    redirect_valid     <= 1'b1;
                    redirect_pc        <= csr_mepc;
                end
                REDIRECT: begin
                    state          <= IDLE;
                    redirect_valid <= 1'b0;
                    redirect_pc    <= RESET_PC;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
- Machine-mode exception/interrupt controller that sits beside the CSR block.
- Consumes the CSR block's mstatus/mie/mip/mtvec/mepc views and the core's per-instruction trap flags.
- Produces the trap-entry and trap-return strobes with new mepc/mcause/mtval, which the CSR block consumes.
- Produces the pipeline flush and PC redirect for the fetch stage.

Parameters:
- RESET_PC, 32'h0000_0000, value driven on redirect_pc while idle/reset (don't-care to fetch).

Ports:
- clk  in  1  core clock
- rst_sync  in  1  synchronous, active-high reset
- stall_n  in  1  pipeline advancing; trap detection only when high
- instr_valid  in  1  a real instruction is at the commit point
- instr_pc  in  32  PC of that instruction
- ecall  in  1  decoded ECALL
- ebreak  in  1  decoded EBREAK
- illegal_instr  in  1  illegal instruction
- instr_misaligned  in  1  jump/branch target misaligned
- mret  in  1  decoded MRET
- csr_mstatus  in  mstatus_t  mie=[3], mpie=[7]
- csr_mie  in  mie_t  msie=[3], mtie=[7], meie=[11]
- csr_mip  in  mip_t  msip=[3], mtip=[7], meip=[11]
- csr_mtvec  in  32  trap vector base/mode
- csr_mepc  in  32  return address
- exception_occurred  out  1  one-cycle trap-entry strobe to CSR
- exception_returned  out  1  one-cycle MRET strobe to CSR
- new_mepc  out  32  mepc to latch
- new_mcause  out  32  mcause to latch
- new_mtval  out  32  constant 0
- flush  out  1  kill all in-flight instructions
- redirect_valid  out  1  fetch must load redirect_pc
- redirect_pc  out  32  new fetch address

Behaviour:
- Reset: state=IDLE; every strobe (exception_occurred, exception_returned, flush, redirect_valid) is 0; new_mepc=0, new_mcause=0, new_mtval=0, redirect_pc=RESET_PC.
- A reset arriving mid-sequence aborts it with no strobe emitted on the following cycle.
- Detection happens in IDLE only, on cycles where instr_valid && stall_n.
- irq_pend = csr_mstatus.mie && |(csr_mie & csr_mip).
- Priority, highest first:
  - Interrupts, ordered MEI (cause 11), then MSI (3), then MTI (7); mcause={1'b1,31'(code)}.
  - Sync exceptions, ordered misaligned (0), illegal (2), ebreak (3), ecall (11); mcause={1'b0,31'(code)}.
  - mret.
- An interrupt pre-empts the instruction: mepc=instr_pc, and that instruction, including an mret, does not execute.
- Sync traps also set mepc=instr_pc.
- FSM states and transitions:
  - IDLE->ENTER when a trap is selected; new_mepc/new_mcause are registered on the transition.
  - IDLE->RET when mret is selected.
  - ENTER: exception_occurred=1 and flush=1 for exactly one cycle; redirect_pc is registered. Direct mode gives {mtvec[31:2],2'b00}.
  - RET: exception_returned=1 and flush=1 for one cycle; redirect_pc=csr_mepc (registered).
  - ENTER/RET->REDIRECT.
  - REDIRECT: redirect_valid=1 for one cycle, then ->IDLE.
- Total latency: detection edge -> strobe on cycle +1 -> redirect on cycle +2.
- ENTER, RET and REDIRECT advance regardless of stall_n.
- Trap flags are ignored outside IDLE; the flushed pipeline supplies no valid flags then.
- Re-entry is prevented because the CSR block clears mstatus.mie at the end of ENTER; the next IDLE cycle sees mie=0.
- new_mepc/new_mcause hold their last value outside ENTER.
- All address arithmetic is 32-bit, with wrap-around ignored.

Optional Feature:
- Macro: TRAP_VECTORED_EN.
- With the macro defined:
  - If mtvec[1:0]==2'b01 and the trap is an interrupt, redirect_pc = {mtvec[31:2],2'b00} + (code<<2).
  - Exceptions always use the base.
  - Mode values 2 and 3 behave as direct.
- Without the macro, mtvec[1:0] is ignored and all traps go to the base.

Decomposition:
- CSR_Typedefs package gains:
  - trap_state_e {IDLE, ENTER, RET, REDIRECT}.
  - Cause code constants: CAUSE_MEI=11, CAUSE_MSI=3, CAUSE_MTI=7, CAUSE_MISALIGN=0, CAUSE_ILLEGAL=2, CAUSE_BREAK=3, CAUSE_ECALL=11.
  - Reuses the existing mstatus_t/mie_t/mip_t.
- One combinational sub-module, trap_cause_arbiter: flags + irq inputs -> take_trap, take_mret, is_irq, cause[30:0].

Test Plan:
- ecall at instr_pc=32'h100 with mtvec=32'h200 -> cycle+1: exception_occurred=1, new_mepc=32'h100, new_mcause=32'd11, flush=1; cycle+2: redirect_valid=1, redirect_pc=32'h200.
- mstatus.mie=1, mie.mtie=1, mip.mtip=1 during an illegal_instr at 32'h40 -> new_mcause=32'h8000_0007, new_mepc=32'h40; the illegal exception is not taken.
- With TRAP_VECTORED_EN, mtvec=32'h301 and MEI+MTI pending -> mcause=32'h8000_000B, redirect_pc=32'h32C. Without the macro, redirect_pc=32'h300.
- mret with csr_mepc=32'h1234 -> cycle+1: exception_returned=1, exception_occurred=0; cycle+2: redirect_pc=32'h1234.
- ecall with stall_n=0 -> no strobe; stall_n rises the next cycle -> trap is taken then, and only once.
- rst_sync asserted during ENTER -> next cycle: all strobes 0, state IDLE, no redirect_valid.
